// File: rtl/note_display_pkg.sv
// ---------------------------------------------------------------------------
// note_display_pkg: glyph codes, segment patterns and note helper functions.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package note_display_pkg;

   localparam int NOTE_W = 7;

   localparam logic [2:0] GLY_BLANK = 3'd0;
   localparam logic [2:0] GLY_C     = 3'd1;
   localparam logic [2:0] GLY_D     = 3'd2;
   localparam logic [2:0] GLY_E     = 3'd3;
   localparam logic [2:0] GLY_F     = 3'd4;
   localparam logic [2:0] GLY_G     = 3'd5;
   localparam logic [2:0] GLY_A     = 3'd6;
   localparam logic [2:0] GLY_B     = 3'd7;

   // {g,f,e,d,c,b,a}, active low
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_G     = 7'b1000010;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;

   function automatic logic [6:0] glyph_to_seg(input logic [2:0] glyph);
      case (glyph)
         GLY_C:   glyph_to_seg = SEG_C;
         GLY_D:   glyph_to_seg = SEG_D;
         GLY_E:   glyph_to_seg = SEG_E;
         GLY_F:   glyph_to_seg = SEG_F;
         GLY_G:   glyph_to_seg = SEG_G;
         GLY_A:   glyph_to_seg = SEG_A;
         GLY_B:   glyph_to_seg = SEG_B;
         default: glyph_to_seg = SEG_BLANK;
      endcase
   endfunction

   // Lowest set key wins; an empty vector maps to blank.
   function automatic logic [2:0] lowest_note(input logic [NOTE_W-1:0] keys);
      lowest_note = GLY_BLANK;
      for (int i = NOTE_W - 1; i >= 0; i--) begin
         if (keys[i]) lowest_note = 3'(i + 1);
      end
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_timer.sv
// ---------------------------------------------------------------------------
// seg_scan_timer: prescaler and digit counter for the display multiplex scan.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg_scan_timer #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 100000,
   localparam int DIG_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   output logic [DIG_W-1:0] digit_idx,
   output logic             digit_tick
);

   localparam int PRE_W = $clog2(SCAN_DIV);

   logic [PRE_W-1:0] pre_q;
   logic [DIG_W-1:0] dig_q;

   assign digit_tick = (pre_q == PRE_W'(SCAN_DIV - 1));
   assign digit_idx  = dig_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q <= '0;
         dig_q <= '0;
      end else if (digit_tick) begin
         pre_q <= '0;
         dig_q <= (dig_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
      end else begin
         pre_q <= pre_q + PRE_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/note_display_scanner.sv
// ---------------------------------------------------------------------------
// note_display_scanner: multiplexed seven-segment note display (live/history).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module note_display_scanner
   import note_display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int NUM_NOTES  = 7,
   parameter int SCAN_DIV   = 100000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_NOTES-1:0]  note_keys,
   input  logic                  mode,
   input  logic                  clear,
   output logic [6:0]            seg_n,
   output logic [NUM_DIGITS-1:0] an_n
);

   localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [DIG_W-1:0]      digit_idx;
   logic                  digit_tick_unused;

   logic [NUM_NOTES-1:0]  keys_q;
   logic [2:0]            hist_q [NUM_DIGITS];
   logic [2:0]            hist_d [NUM_DIGITS];
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;

   logic [NOTE_W-1:0]     keys_ext, new_ext;
   logic [2:0]            cur_glyph;

   seg_scan_timer #(
      .NUM_DIGITS (NUM_DIGITS),
      .SCAN_DIV   (SCAN_DIV)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .digit_idx  (digit_idx),
      .digit_tick (digit_tick_unused)
   );

   always_comb begin
      keys_ext                  = '0;
      keys_ext[NUM_NOTES-1:0]   = note_keys;
      new_ext                   = '0;
      new_ext[NUM_NOTES-1:0]    = note_keys & ~keys_q;
   end

   // Clear beats a same-cycle press; the press is simply lost.
   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) hist_d[i] = hist_q[i];
      if (clear) begin
         for (int i = 0; i < NUM_DIGITS; i++) hist_d[i] = GLY_BLANK;
      end else if (|new_ext) begin
         hist_d[0] = lowest_note(new_ext);
         for (int i = 1; i < NUM_DIGITS; i++) hist_d[i] = hist_q[i-1];
      end
   end

   always_comb begin
      if (mode) begin
         cur_glyph = hist_q[digit_idx];
      end else begin
         cur_glyph = (digit_idx == '0) ? lowest_note(keys_ext) : GLY_BLANK;
      end
      seg_d = glyph_to_seg(cur_glyph);
      an_d  = '1;
      for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = (digit_idx != DIG_W'(i));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         keys_q <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) hist_q[i] <= GLY_BLANK;
         seg_q  <= SEG_BLANK;
         an_q   <= '1;
      end else begin
         keys_q <= note_keys;
         for (int i = 0; i < NUM_DIGITS; i++) hist_q[i] <= hist_d[i];
         seg_q  <= seg_d;
         an_q   <= an_d;
      end
   end

   assign seg_n = seg_q;
   assign an_n  = an_q;

endmodule

`default_nettype wire

// File: tb/tb_note_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_note_display_scanner: scoreboard bench for note_display_scanner.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_note_display_scanner;

   localparam logic [6:0] S_BL = 7'b1111111;
   localparam logic [6:0] S_C  = 7'b1000110;
   localparam logic [6:0] S_D  = 7'b0100001;
   localparam logic [6:0] S_E  = 7'b0000110;
   localparam logic [6:0] S_F  = 7'b0001110;
   localparam logic [6:0] S_G  = 7'b1000010;
   localparam logic [6:0] S_A  = 7'b0001000;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] note_keys;
   logic       mode;
   logic       clear;
   logic [6:0] seg_n;
   logic [3:0] an_n;

   int tests = 0;
   int fails = 0;

   // exact: compare at the next negedge; otherwise wait for that anode.
   typedef struct {
      bit         exact;
      logic [3:0] an;
      logic [6:0] seg;
      string      name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   note_display_scanner #(
      .NUM_DIGITS (4),
      .NUM_NOTES  (7),
      .SCAN_DIV   (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .note_keys (note_keys),
      .mode      (mode),
      .clear     (clear),
      .seg_n     (seg_n),
      .an_n      (an_n)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         if (sb[0].exact || an_n == sb[0].an) begin
            mon_e = sb.pop_front();
            tests++;
            if (an_n !== mon_e.an || seg_n !== mon_e.seg) begin
               fails++;
               $display("FAIL %s: an_n=%b seg_n=%b, expected an_n=%b seg_n=%b",
                        mon_e.name, an_n, seg_n, mon_e.an, mon_e.seg);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exact(input logic [3:0] an, input logic [6:0] seg, input string name);
      exp_t e;
      e.exact = 1'b1; e.an = an; e.seg = seg; e.name = name;
      sb.push_back(e);
   endtask

   task automatic push_digit(input int d, input logic [6:0] seg, input string name);
      exp_t e;
      logic [3:0] one;
      one = 4'b0001;
      e.exact = 1'b0; e.an = ~(one << d); e.seg = seg; e.name = name;
      sb.push_back(e);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: %0d checks pending, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic press(input int k);
      note_keys = 7'(1 << k);
      cyc(2);
      note_keys = '0;
      cyc(2);
   endtask

   initial begin
      logic [3:0] one;
      bit         found;
      one       = 4'b0001;
      reset     = 1'b1;
      note_keys = '0;
      mode      = 1'b0;
      clear     = 1'b0;

      // Reset state and scan order
      repeat (3) @(posedge clk);
      #1;
      push_exact(4'b1111, S_BL, "reset_state");
      reset = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         cyc(1);
         push_exact(~(one << (((k - 1) / 4) % 4)), S_BL, "scan_seq");
      end
      drain("scan");

      // History of C, E, G
      mode = 1'b1;
      press(0); press(2); press(4);
      cyc(2);
      push_digit(0, S_G,  "hist_ceg_d0");
      push_digit(1, S_E,  "hist_ceg_d1");
      push_digit(2, S_C,  "hist_ceg_d2");
      push_digit(3, S_BL, "hist_ceg_d3");
      drain("hist_ceg");

      // Simultaneous D and A: only D recorded, holding adds nothing
      note_keys = 7'b0100010;
      cyc(3);
      push_digit(0, S_D, "simul_d0");
      push_digit(1, S_G, "simul_d1");
      push_digit(2, S_E, "simul_d2");
      push_digit(3, S_C, "simul_d3");
      drain("simul");
      cyc(50);
      push_digit(0, S_D, "held_d0");
      push_digit(1, S_G, "held_d1");
      drain("held");
      note_keys = '0;
      cyc(2);
      press(5);
      push_digit(0, S_A, "repress_d0");
      push_digit(1, S_D, "repress_d1");
      push_digit(2, S_G, "repress_d2");
      push_digit(3, S_E, "repress_d3");
      drain("repress");

      // Five presses push the oldest out
      for (int k = 0; k < 5; k++) press(k);
      push_digit(0, S_G, "five_d0");
      push_digit(1, S_F, "five_d1");
      push_digit(2, S_E, "five_d2");
      push_digit(3, S_D, "five_d3");
      drain("five");

      // Clear beats a same-cycle B press
      note_keys = 7'b1000000;
      clear     = 1'b1;
      cyc(1);
      clear     = 1'b0;
      cyc(1);
      note_keys = '0;
      cyc(2);
      for (int d = 0; d < 4; d++) push_digit(d, S_BL, "clear_blank");
      drain("clear");
      press(0);
      push_digit(0, S_C,  "after_clear_d0");
      push_digit(1, S_BL, "after_clear_d1");
      drain("after_clear");

      // Live mode
      mode      = 1'b0;
      note_keys = 7'b1001000;
      cyc(3);
      push_digit(0, S_F,  "live_d0");
      push_digit(1, S_BL, "live_d1");
      push_digit(2, S_BL, "live_d2");
      push_digit(3, S_BL, "live_d3");
      drain("live");
      note_keys = '0;
      cyc(2);
      push_digit(0, S_BL, "live_release_d0");
      drain("live_release");

      // Reset mid-scan at digit 2, then history must be empty
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (an_n == 4'b1011) found = 1'b1;
      end
      if (!found) begin
         tests++;
         fails++;
         $display("FAIL digit2_wait: an_n=%b, expected 1011 within 40 cycles", an_n);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc(1);
      push_exact(4'b1111, S_BL, "midscan_reset");
      reset = 1'b0;
      mode  = 1'b1;
      cyc(1);
      push_exact(4'b1110, S_BL, "post_reset_first");
      drain("midscan_reset");
      for (int d = 0; d < 4; d++) push_digit(d, S_BL, "post_reset_hist");
      drain("post_reset_hist");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/note_display_scanner.md
Name: note_display_scanner

Overview:
Multiplexed multi-digit seven-segment driver for the piano front panel.
- Captures note-key presses and shows the current note (live mode) or a scrolling history of the last NUM_DIGITS notes (history mode).
- Time-multiplexes the digits with active-low anodes and segments.
- Sits between the debounced key bank and the board display pins.
- Generalises the single-digit combinational note decoder: adds digit count, glyph set, scan timing and note memory.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
NUM_NOTES, 7, one-hot note key inputs, index 0..6 = C D E F G A B (1..7)
SCAN_DIV, 100000, clk cycles each digit stays lit (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
note_keys  in  NUM_NOTES  held-key vector, already debounced and synchronous to clk
mode  in  1  0 = live, 1 = history
clear  in  1  synchronous history clear, 1-cycle or level
seg_n  out  7  segments {g,f,e,d,c,b,a}, active low
an_n  out  NUM_DIGITS  digit anodes, active low, one-hot-low

Behaviour:
- Glyph codes are 3-bit: 0 = blank, 1..7 = C D E F G A B.
- Segment patterns ({g..a}, active low):
  - blank 1111111
  - C 1000110
  - d 0100001
  - E 0000110
  - F 0001110
  - G 1000010
  - A 0001000
  - b 0000011
- Reset:
  - prescaler = 0, digit_idx = 0, keys_q = 0.
  - All history entries = blank.
  - seg_n = 1111111, an_n = all ones.
- Scan timing:
  - Prescaler counts 0..SCAN_DIV-1.
  - On the cycle it equals SCAN_DIV-1, it wraps to 0 and digit_idx advances, wrapping NUM_DIGITS-1 -> 0.
- Outputs are registered from the current digit_idx and glyph, so they lag by 1 cycle.
  - First cycle after reset deasserts: an_n = ~(1<<0), seg_n = blank.
  - an_n always has exactly one low bit after reset.
- Press detection:
  - new = note_keys & ~keys_q; keys_q <= note_keys every cycle.
  - If new != 0, the press glyph is the lowest set index of new, plus 1.
  - Simultaneous new presses record only the lowest note.
  - Held keys never re-trigger.
  - Release produces no event.
- History push on a press:
  - hist[0] <= glyph; hist[i] <= hist[i-1] for i = 1..NUM_DIGITS-1.
  - hist[NUM_DIGITS-1] is discarded.
  - The update is visible to the scan at the next cycle.
- clear:
  - All hist entries go to blank.
  - clear has priority over a same-cycle press: the press is dropped, but keys_q still updates.
- Live mode (mode = 0):
  - Digit 0 shows the lowest-index currently held key, or blank if none.
  - Other digits show blank.
  - History continues recording in the background.
- History mode (mode = 1): digit i shows hist[i]; digit 0 is the newest.
- mode changes take effect on the next output register update; the scan is not restarted.
- Reset mid-scan returns to the reset state on the next edge, regardless of other inputs.
- Decimal point is not driven (no port).

Decomposition:
- Package note_display_pkg:
  - glyph code localparams (GLY_BLANK, GLY_C..GLY_B).
  - 7-bit segment constants.
  - function glyph_to_seg (3-bit -> 7-bit; unknown -> blank).
  - function lowest_note (vector -> glyph).
- Sub-module seg_scan_timer (params NUM_DIGITS, SCAN_DIV; ports clk, reset, digit_idx out, digit_tick out) holds the prescaler and digit counter.
- Top level holds edge detect, history shift register and output registers.

Test Plan:
1. Bench parameters NUM_DIGITS = 4, SCAN_DIV = 4.
   Reset held 3 cycles -> seg_n = 1111111, an_n = 1111. After release, an_n sequence 1110 x4, 1101 x4, 1011 x4, 0111 x4, then 1110 again.
2. History mode, pulses on keys 0, 2, 4 (C, E, G), each held 2 cycles and separated -> hist = {G,E,C,blank}.
   Digit 0 shows 1000010, digit 1 shows 0000110, digit 2 shows 1000110, digit 3 shows 1111111.
3. History mode, keys 1 and 5 rise in the same cycle -> only D recorded (digit 0 = 0100001).
   Holding both for 50 cycles adds no entries. Releasing and re-pressing key 5 pushes A (0001000).
4. History mode, five presses C D E F G -> C shifted out. Digits 0..3 = G, F, E, D.
5. Press B while clear = 1 -> all digits blank, B not recorded. The next press of C alone -> digit 0 = 1000110.
6. Live mode: hold keys 3 and 6 -> digit 0 = F (0001110), digits 1..3 blank.
   Release all keys -> digit 0 blank. Assert reset mid-scan at digit 2 -> next cycle an_n = 1111, history empty.
